axi_lite_write_arbiter: RTL
===========================

Name: axi_lite_write_arbiter

Overview:
- Two-master to one-slave arbiter for the AXI4-Lite write path: AW, W and B channels.
- Grants one whole write transaction (address, data, response) to one master at a time, using round-robin priority.
- Sits between the write-address/write-data masters and the single write-address/write-data slave.
- Routes the B response back to the granted master only.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR on all ports.
- DATA_WIDTH, 32, width of WDATA; WSTRB width is DATA_WIDTH/8.

Ports:
- ACLK  input  1  clock; all state changes on the rising edge.
- ARESETn  input  1  asynchronous active-low reset.
- m0_awaddr, m1_awaddr  input  ADDR_WIDTH each  master write addresses.
- m0_awprot, m1_awprot  input  3 each  master protection bits.
- m0_awvalid, m1_awvalid  input  1 each  master address valid; also acts as the arbitration request.
- m0_awready, m1_awready  output  1 each  address ready to masters.
- m0_wdata, m1_wdata  input  DATA_WIDTH each  master write data.
- m0_wstrb, m1_wstrb  input  DATA_WIDTH/8 each  master byte strobes.
- m0_wvalid, m1_wvalid  input  1 each  master data valid.
- m0_wready, m1_wready  output  1 each  data ready to masters.
- m0_bresp, m1_bresp  output  2 each  response to masters.
- m0_bvalid, m1_bvalid  output  1 each  response valid to masters.
- m0_bready, m1_bready  input  1 each  master response ready.
- s_awaddr  output  ADDR_WIDTH  address to slave.
- s_awprot  output  3  protection bits to slave.
- s_awvalid  output  1  address valid to slave.
- s_awready  input  1  slave address ready.
- s_wdata  output  DATA_WIDTH  data to slave.
- s_wstrb  output  DATA_WIDTH/8  strobes to slave.
- s_wvalid  output  1  data valid to slave.
- s_wready  input  1  slave data ready.
- s_bresp  input  2  slave response.
- s_bvalid  input  1  slave response valid.
- s_bready  output  1  response ready to slave.
- grant  output  1  index of the currently or last granted master (0 = m0).
- busy  output  1  high while in XFER or RESP.

Behaviour:
- State machine: IDLE -> XFER -> RESP -> IDLE. Registers: state, grant, aw_done, w_done, last (last master served).
- Reset (ARESETn low, asynchronous):
  - state = IDLE, grant = 0, last = 1 (m0 gets first priority), aw_done = w_done = 0.
  - All VALID/READY outputs = 0, all bresp outputs = 0, busy = 0.
- IDLE:
  - No ready or valid is asserted on any port.
  - If exactly one of m0_awvalid/m1_awvalid is high, grant that master.
  - If both are high, grant the master that is not `last`.
  - On grant: load grant, go to XFER. Arbitration costs exactly 1 cycle.
  - No request: stay in IDLE.
- XFER:
  - s_aw* and s_w* are combinationally muxed from the granted master.
  - s_awvalid = granted awvalid & !aw_done; s_wvalid = granted wvalid & !w_done.
  - Granted awready = s_awready & !aw_done; granted wready = s_wready & !w_done.
  - Non-granted master sees awready = wready = 0.
  - aw_done is set on the s_awvalid & s_awready handshake; w_done is set on the s_wvalid & s_wready handshake.
  - AW and W complete independently, in either order or in the same cycle.
  - Go to RESP in the cycle after both flags are set; also go to RESP directly when the final handshakes occur in the same cycle.
- RESP:
  - Granted bvalid = s_bvalid and granted bresp = s_bresp; s_bready = granted bready.
  - Non-granted master sees bvalid = 0 and bresp = 0.
  - On s_bvalid & s_bready: last <= grant, clear aw_done/w_done, go to IDLE.
- Once a VALID is forwarded, it is never withdrawn by the arbiter, and grant never changes mid-transaction.
- Minimum transaction with zero-wait slave and masters: grant edge, AW+W handshake edge, B handshake edge; 3 edges total. Back-to-back transactions have 1 idle cycle between them.
- A master raising wvalid without awvalid is not a request; it waits until its awvalid wins arbitration.
- Reset mid-transaction immediately returns to the reset values; partially completed handshakes are abandoned.
- bresp passes through unmodified; SLVERR and DECERR values are forwarded.

Test Plan:
- Single master: m0 writes awaddr=0x0000_1000, wdata=0xDEAD_BEEF, wstrb=0xF; slave ready, bresp=0. -> s_awaddr=0x1000 and s_wdata=0xDEADBEEF during XFER; m0_bvalid=1 with bresp=0; m1 sees no ready or valid; grant=0.
- Simultaneous requests: m0 and m1 both assert awvalid after reset, each issuing two transactions. -> Grant order is m0, m1, m0, m1; each slave transaction carries the correct master's addr/data.
- W before AW: granted master's wvalid handshakes 2 cycles before s_awready rises. -> w_done holds, s_wvalid drops after the handshake, exactly one W beat reaches the slave, RESP is entered after AW completes.
- Backpressure: s_bvalid=1 with bresp=2'b10 while m1_bready=0 for 4 cycles. -> m1_bvalid stays 1 with bresp=2'b10, state holds in RESP, then returns to IDLE on the cycle after m1_bready rises.
- Reset mid-XFER: drop ARESETn after the AW handshake but before W. -> All outputs go to 0 immediately, busy=0, grant=0; the next request is granted to m0.
- Lone W request: m1_wvalid=1, m1_awvalid=0 for 5 cycles. -> State stays IDLE, m1_wready=0, s_wvalid=0.

Source files
------------

// File: rtl/axi_lite_write_arbiter.sv
// Two-master to one-slave AXI4-Lite write arbiter (AW, W, B) with round-robin grant.
// Latency: 1 cycle arbitration, then AW/W pass combinationally, B returned to the granted master.
// Backpressure: slave ready/valid pass straight through to the granted master; the other master sees no ready/valid.
module axi_lite_write_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   // master 0
   input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
   input  logic [2:0]              m0_awprot,
   input  logic                    m0_awvalid,
   output logic                    m0_awready,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
   input  logic                    m0_wvalid,
   output logic                    m0_wready,
   output logic [1:0]              m0_bresp,
   output logic                    m0_bvalid,
   input  logic                    m0_bready,
   // master 1
   input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
   input  logic [2:0]              m1_awprot,
   input  logic                    m1_awvalid,
   output logic                    m1_awready,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
   input  logic                    m1_wvalid,
   output logic                    m1_wready,
   output logic [1:0]              m1_bresp,
   output logic                    m1_bvalid,
   input  logic                    m1_bready,
   // slave
   output logic [ADDR_WIDTH-1:0]   s_awaddr,
   output logic [2:0]              s_awprot,
   output logic                    s_awvalid,
   input  logic                    s_awready,
   output logic [DATA_WIDTH-1:0]   s_wdata,
   output logic [DATA_WIDTH/8-1:0] s_wstrb,
   output logic                    s_wvalid,
   input  logic                    s_wready,
   input  logic [1:0]              s_bresp,
   input  logic                    s_bvalid,
   output logic                    s_bready,
   // status
   output logic                    grant,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   logic   last;       // master served most recently; loses a tie
   logic   aw_done;
   logic   w_done;

   logic   in_xfer;
   logic   in_resp;
   logic   sel_awvalid;
   logic   sel_wvalid;
   logic   sel_bready;
   logic   aw_hs;
   logic   w_hs;
   logic   awready_g;
   logic   wready_g;
   logic   bvalid_g;

   assign in_xfer = (state == XFER);
   assign in_resp = (state == RESP);
   assign busy    = in_xfer | in_resp;

   // Steer the granted master's request/data onto the slave side and the slave's
   // ready/response back to that master only.
   always_comb begin
      sel_awvalid = grant ? m1_awvalid : m0_awvalid;
      sel_wvalid  = grant ? m1_wvalid  : m0_wvalid;
      sel_bready  = grant ? m1_bready  : m0_bready;

      s_awaddr    = grant ? m1_awaddr  : m0_awaddr;
      s_awprot    = grant ? m1_awprot  : m0_awprot;
      s_wdata     = grant ? m1_wdata   : m0_wdata;
      s_wstrb     = grant ? m1_wstrb   : m0_wstrb;

      // a channel that already handshook is masked so exactly one beat reaches the slave
      s_awvalid   = in_xfer & sel_awvalid & ~aw_done;
      s_wvalid    = in_xfer & sel_wvalid  & ~w_done;
      awready_g   = in_xfer & s_awready   & ~aw_done;
      wready_g    = in_xfer & s_wready    & ~w_done;
      bvalid_g    = in_resp & s_bvalid;
      s_bready    = in_resp & sel_bready;

      aw_hs       = s_awvalid & s_awready;
      w_hs        = s_wvalid  & s_wready;

      m0_awready  = awready_g & ~grant;
      m1_awready  = awready_g &  grant;
      m0_wready   = wready_g  & ~grant;
      m1_wready   = wready_g  &  grant;
      m0_bvalid   = bvalid_g  & ~grant;
      m1_bvalid   = bvalid_g  &  grant;
      m0_bresp    = (in_resp & ~grant) ? s_bresp : 2'b00;
      m1_bresp    = (in_resp &  grant) ? s_bresp : 2'b00;
   end

   // Transaction sequencer: arbitrate, collect AW and W in any order, wait for B.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state   <= IDLE;
         grant   <= 1'b0;
         last    <= 1'b1;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_awvalid | m1_awvalid) begin
                  grant <= (m0_awvalid & m1_awvalid) ? ~last : m1_awvalid;
                  state <= XFER;
               end
            end
            XFER: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
               if ((aw_done | aw_hs) && (w_done | w_hs)) state <= RESP;
            end
            RESP: begin
               if (s_bvalid & s_bready) begin
                  last    <= grant;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
